tsu_axis_rx_latency: RTL and testbench

- Receive-side partner of the TX timestamp inserter.
- Passively monitors the MAC RX AXI-Stream byte stream and stamps each frame's first beat with the local RTC.
- For critical-Ethertype frames, extracts the 64-bit TX timestamp carried in payload bytes 20..27 and computes one-way latency = rx_ts - tx_ts.
- Results go to the host/stats logic through a one-entry valid/ready register; frame, critical, runt and overflow counters are also kept.

---
 rtl/tsu_pkg.sv | 21 ++
 rtl/tsu_rx_frame_parser.sv | 130 +++++++++++++
 rtl/tsu_axis_rx_latency.sv | 134 +++++++++++++
 tb/tb_tsu_axis_rx_latency.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tsu_pkg.sv
// Shared types and constants for the RX latency monitor: FSM encoding,
// result record layout and the default critical Ethertype.
package tsu_pkg;

    localparam int          TS_BYTES       = 8;
    localparam int          ETYPE_OFS      = 12;
    localparam logic [15:0] CRIT_ETYPE_DEF = 16'h88B5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } tsu_state_e;

    typedef struct packed {
        logic [63:0] tx_ts;
        logic [63:0] rx_ts;
        logic [63:0] latency;
        logic        negative;
    } tsu_res_t;

endpackage

// File: rtl/tsu_rx_frame_parser.sv
// Per-frame byte tracking: beat index, Ethertype match and big-endian
// extraction of the embedded TX timestamp.
module tsu_rx_frame_parser
    import tsu_pkg::*;
#(
    parameter logic [15:0] CRIT_ETYPE = CRIT_ETYPE_DEF,
    parameter int          TS_OFFSET  = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tvalid,
    input  logic        i_tready,
    input  logic [7:0]  i_tdata,
    input  logic        i_tlast,
    output logic        o_sof_beat,
    output logic        o_eof_beat,
    output logic        o_crit,
    output logic        o_ts_done,
    output logic [63:0] o_tx_ts
);

    localparam logic [5:0] TS_LO  = 6'(TS_OFFSET);
    localparam logic [5:0] TS_HI  = 6'(TS_OFFSET + TS_BYTES - 1);
    localparam logic [5:0] ET_HI  = 6'(ETYPE_OFS);
    localparam logic [5:0] ET_LO  = 6'(ETYPE_OFS + 1);

    tsu_state_e  r_state;
    tsu_state_e  w_state_nxt;
    logic [5:0]  r_bcnt;
    logic        r_etype_hi_ok;
    logic        r_crit;
    logic        r_ts_done;
    logic [63:0] r_tx_shift;

    logic        w_beat;
    logic        w_sof;
    logic [5:0]  w_idx;
    logic        w_in_ts;
    logic        w_crit_now;
    logic [63:0] w_tx_next;

    // The outputs include the current beat so a frame ending on the last
    // Ethertype or timestamp byte is judged with that byte already counted.
    always_comb begin
        w_beat     = i_tvalid & i_tready;
        w_sof      = w_beat & (r_state == IDLE);
        w_idx      = (r_state == IDLE) ? 6'd0 : r_bcnt;
        w_in_ts    = w_beat && (w_idx >= TS_LO) && (w_idx <= TS_HI);
        w_crit_now = w_beat && (w_idx == ET_LO) && r_etype_hi_ok &&
                     (i_tdata == CRIT_ETYPE[7:0]);
        if (w_in_ts) begin
            w_tx_next = {r_tx_shift[55:0], i_tdata};
        end else begin
            w_tx_next = r_tx_shift;
        end
        o_sof_beat = w_sof;
        o_eof_beat = w_beat & i_tlast;
        o_crit     = r_crit | w_crit_now;
        o_ts_done  = r_ts_done | (w_in_ts && (w_idx == TS_HI));
        o_tx_ts    = w_tx_next;
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_beat && !i_tlast) begin
                    w_state_nxt = FRAME;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FRAME: begin
                if (w_beat && i_tlast) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FRAME;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte counter, Ethertype flags and timestamp shift register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bcnt        <= 6'd0;
            r_etype_hi_ok <= 1'b0;
            r_crit        <= 1'b0;
            r_ts_done     <= 1'b0;
            r_tx_shift    <= 64'd0;
        end else if (w_beat && i_tlast) begin
            r_bcnt        <= 6'd0;
            r_etype_hi_ok <= 1'b0;
            r_crit        <= 1'b0;
            r_ts_done     <= 1'b0;
            r_tx_shift    <= 64'd0;
        end else if (w_beat) begin
            r_bcnt <= (w_idx == 6'd63) ? 6'd63 : (w_idx + 6'd1);
            if (w_sof) begin
                r_etype_hi_ok <= 1'b0;
                r_crit        <= 1'b0;
                r_ts_done     <= 1'b0;
                r_tx_shift    <= 64'd0;
            end else begin
                if (w_idx == ET_HI) begin
                    r_etype_hi_ok <= (i_tdata == CRIT_ETYPE[15:8]);
                end
                if (w_crit_now) begin
                    r_crit <= 1'b1;
                end
                if (o_ts_done) begin
                    r_ts_done <= 1'b1;
                end
                r_tx_shift <= w_tx_next;
            end
        end
    end

endmodule

// File: rtl/tsu_axis_rx_latency.sv
// RX-side latency monitor: stamps each frame's first beat with the RTC and
// reports rx_ts - tx_ts for critical frames through a one-entry register.
module tsu_axis_rx_latency
    import tsu_pkg::*;
#(
    parameter logic [15:0] CRIT_ETYPE = CRIT_ETYPE_DEF,
    parameter int          TS_OFFSET  = 20,
    parameter int          CNT_W      = 32
) (
    input  logic             mac_axis_aclk,
    input  logic             rst_n,
    input  logic             mac_axis_tvalid,
    input  logic             mac_axis_tready,
    input  logic [7:0]       mac_axis_tdata,
    input  logic             mac_axis_tlast,
    input  logic [63:0]      rtc_timer_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_tx_ts,
    output logic [63:0]      res_rx_ts,
    output logic [63:0]      res_latency,
    output logic             res_negative,
    output logic [CNT_W-1:0] cnt_frames,
    output logic [CNT_W-1:0] cnt_critical,
    output logic [CNT_W-1:0] cnt_runt,
    output logic [CNT_W-1:0] cnt_overflow
);

    logic        w_sof;
    logic        w_eof;
    logic        w_crit;
    logic        w_ts_done;
    logic [63:0] w_tx_ts;
    logic        w_gen;
    logic        w_runt;
    logic        w_load;
    tsu_res_t    w_res;

    logic [63:0]      r_rx_ts;
    logic             r_valid;
    tsu_res_t         r_res;
    logic [CNT_W-1:0] r_cnt_frames;
    logic [CNT_W-1:0] r_cnt_critical;
    logic [CNT_W-1:0] r_cnt_runt;
    logic [CNT_W-1:0] r_cnt_overflow;

    tsu_rx_frame_parser #(
        .CRIT_ETYPE (CRIT_ETYPE),
        .TS_OFFSET  (TS_OFFSET)
    ) u_parser (
        .i_clk      (mac_axis_aclk),
        .i_rst_n    (rst_n),
        .i_tvalid   (mac_axis_tvalid),
        .i_tready   (mac_axis_tready),
        .i_tdata    (mac_axis_tdata),
        .i_tlast    (mac_axis_tlast),
        .o_sof_beat (w_sof),
        .o_eof_beat (w_eof),
        .o_crit     (w_crit),
        .o_ts_done  (w_ts_done),
        .o_tx_ts    (w_tx_ts)
    );

    // Result classification and the record that would be loaded this cycle.
    always_comb begin
        w_gen            = w_eof & w_crit & w_ts_done;
        w_runt           = w_eof & w_crit & ~w_ts_done;
        w_load           = w_gen & (~r_valid | res_ready);
        w_res.tx_ts      = w_tx_ts;
        w_res.rx_ts      = r_rx_ts;
        w_res.latency    = r_rx_ts - w_tx_ts;
        w_res.negative   = w_res.latency[63];
    end

    // RX timestamp capture on the first beat of every frame.
    always_ff @(posedge mac_axis_aclk) begin
        if (!rst_n) begin
            r_rx_ts <= 64'd0;
        end else if (w_sof) begin
            r_rx_ts <= rtc_timer_in;
        end else begin
            r_rx_ts <= r_rx_ts;
        end
    end

    // One-entry result register; a full, unread entry wins over a new one.
    always_ff @(posedge mac_axis_aclk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
        end else if (r_valid && res_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge mac_axis_aclk) begin
        if (!rst_n) begin
            r_cnt_frames   <= '0;
            r_cnt_critical <= '0;
            r_cnt_runt     <= '0;
            r_cnt_overflow <= '0;
        end else begin
            if (w_eof) begin
                r_cnt_frames <= r_cnt_frames + CNT_W'(1);
            end
            if (w_gen) begin
                r_cnt_critical <= r_cnt_critical + CNT_W'(1);
            end
            if (w_runt) begin
                r_cnt_runt <= r_cnt_runt + CNT_W'(1);
            end
            if (w_gen && !w_load) begin
                r_cnt_overflow <= r_cnt_overflow + CNT_W'(1);
            end
        end
    end

    assign res_valid    = r_valid;
    assign res_tx_ts    = r_res.tx_ts;
    assign res_rx_ts    = r_res.rx_ts;
    assign res_latency  = r_res.latency;
    assign res_negative = r_res.negative;
    assign cnt_frames   = r_cnt_frames;
    assign cnt_critical = r_cnt_critical;
    assign cnt_runt     = r_cnt_runt;
    assign cnt_overflow = r_cnt_overflow;

endmodule

// File: tb/tb_tsu_axis_rx_latency.sv
// Directed bench for the RX latency monitor with hand-computed expectations.
module tb_tsu_axis_rx_latency;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready = 1'b0;
    logic [7:0]  tdata = 8'd0;
    logic        tlast = 1'b0;
    logic [63:0] rtc = 64'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_tx_ts;
    logic [63:0] res_rx_ts;
    logic [63:0] res_latency;
    logic        res_negative;
    logic [31:0] cnt_frames;
    logic [31:0] cnt_critical;
    logic [31:0] cnt_runt;
    logic [31:0] cnt_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tsu_axis_rx_latency dut (
        .mac_axis_aclk   (clk),
        .rst_n           (rst_n),
        .mac_axis_tvalid (tvalid),
        .mac_axis_tready (tready),
        .mac_axis_tdata  (tdata),
        .mac_axis_tlast  (tlast),
        .rtc_timer_in    (rtc),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_tx_ts       (res_tx_ts),
        .res_rx_ts       (res_rx_ts),
        .res_latency     (res_latency),
        .res_negative    (res_negative),
        .cnt_frames      (cnt_frames),
        .cnt_critical    (cnt_critical),
        .cnt_runt        (cnt_runt),
        .cnt_overflow    (cnt_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int i, input logic [15:0] et, input logic [63:0] ts);
        if (i == 12)                return et[15:8];
        else if (i == 13)           return et[7:0];
        else if (i >= 20 && i <= 27) return ts[8*(27-i) +: 8];
        else                        return 8'(i);
    endfunction

    // Sends len bytes; returns at the negedge after the last beat.
    task automatic send_frame(input int len, input logic [15:0] et, input logic [63:0] txts,
                              input logic [63:0] rtc0, input bit stall, input bit no_last,
                              input bit rdy_last);
        if (stall) begin
            @(negedge clk);
            tvalid = 1'b1; tready = 1'b0; tdata = 8'hFF; tlast = 1'b1; rtc = rtc0 - 64'd1;
        end
        for (int i = 0; i < len; i++) begin
            if (stall && i > 0 && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                tvalid = 1'($urandom_range(0, 1));
                tready = ~tvalid;
                tdata  = 8'($urandom);
                tlast  = 1'($urandom);
                rtc    = rtc + 64'd1;
            end
            @(negedge clk);
            tvalid = 1'b1; tready = 1'b1;
            tdata  = fbyte(i, et, txts);
            tlast  = (i == len - 1) && !no_last;
            rtc    = (i == 0) ? rtc0 : rtc + 64'd3;
            if (rdy_last && i == len - 1) res_ready = 1'b1;
        end
        @(negedge clk);
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; rtc = rtc + 64'd3;
        if (rdy_last) res_ready = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_tx", res_tx_ts, 64'd0);
        chk("rst_lat", res_latency, 64'd0);
        chk("rst_frames", 64'(cnt_frames), 64'd0);
        chk("rst_crit", 64'(cnt_critical), 64'd0);
        rst_n = 1'b1;

        // Basic critical frame
        send_frame(64, 16'h88B5, 64'd1000, 64'h7D0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_tx", res_tx_ts, 64'd1000);
        chk("t1_rx", res_rx_ts, 64'd2000);
        chk("t1_lat", res_latency, 64'd1000);
        chk("t1_neg", 64'(res_negative), 64'd0);
        chk("t1_frames", 64'(cnt_frames), 64'd1);
        chk("t1_crit", 64'(cnt_critical), 64'd1);
        @(negedge clk);
        chk("t1_hold", 64'(res_valid), 64'd1);
        consume();
        chk("t1_consumed", 64'(res_valid), 64'd0);

        // Non-critical Ethertype
        send_frame(64, 16'h0800, 64'd55, 64'd77, 1'b0, 1'b0, 1'b0);
        chk("t2_valid", 64'(res_valid), 64'd0);
        chk("t2_frames", 64'(cnt_frames), 64'd2);
        chk("t2_crit", 64'(cnt_critical), 64'd1);

        // Runt critical frame, then a one-byte frame
        send_frame(25, 16'h88B5, 64'd9, 64'd99, 1'b0, 1'b0, 1'b0);
        chk("t3_valid", 64'(res_valid), 64'd0);
        chk("t3_runt", 64'(cnt_runt), 64'd1);
        chk("t3_frames", 64'(cnt_frames), 64'd3);
        send_frame(1, 16'h88B5, 64'd9, 64'd99, 1'b0, 1'b0, 1'b0);
        chk("t3b_frames", 64'(cnt_frames), 64'd4);
        chk("t3b_valid", 64'(res_valid), 64'd0);
        chk("t3b_crit", 64'(cnt_critical), 64'd1);

        // Back-to-back with consumer stalled, then replace on ready
        send_frame(30, 16'h88B5, 64'h100, 64'h500, 1'b0, 1'b0, 1'b0);
        chk("t4a_tx", res_tx_ts, 64'h100);
        send_frame(30, 16'h88B5, 64'h200, 64'h900, 1'b0, 1'b0, 1'b0);
        chk("t4b_valid", 64'(res_valid), 64'd1);
        chk("t4b_tx_held", res_tx_ts, 64'h100);
        chk("t4b_rx_held", res_rx_ts, 64'h500);
        chk("t4b_lat_held", res_latency, 64'h400);
        chk("t4b_ovf", 64'(cnt_overflow), 64'd1);
        chk("t4b_crit", 64'(cnt_critical), 64'd3);
        send_frame(30, 16'h88B5, 64'h300, 64'hA00, 1'b0, 1'b0, 1'b1);
        chk("t4c_valid", 64'(res_valid), 64'd1);
        chk("t4c_tx", res_tx_ts, 64'h300);
        chk("t4c_lat", res_latency, 64'h700);
        chk("t4c_ovf", 64'(cnt_overflow), 64'd1);
        chk("t4c_crit", 64'(cnt_critical), 64'd4);
        consume();

        // Negative latency with stalls
        send_frame(40, 16'h88B5, 64'h10, 64'h08, 1'b1, 1'b0, 1'b0);
        chk("t5_valid", 64'(res_valid), 64'd1);
        chk("t5_rx", res_rx_ts, 64'h08);
        chk("t5_lat", res_latency, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t5_neg", 64'(res_negative), 64'd1);
        consume();

        // tlast exactly on the last timestamp byte
        send_frame(28, 16'h88B5, 64'hAABB_CCDD_1122_3344, 64'hAABB_CCDD_1122_3350, 1'b1, 1'b0, 1'b0);
        chk("t6_valid", 64'(res_valid), 64'd1);
        chk("t6_tx", res_tx_ts, 64'hAABB_CCDD_1122_3344);
        chk("t6_lat", res_latency, 64'hC);
        chk("t6_runt", 64'(cnt_runt), 64'd1);
        consume();

        // Saturated byte counter
        send_frame(70, 16'h88B5, 64'd5, 64'd9, 1'b0, 1'b0, 1'b0);
        chk("t7_lat", res_latency, 64'd4);
        chk("t7_frames", 64'(cnt_frames), 64'd10);
        chk("t7_crit", 64'(cnt_critical), 64'd7);

        // Reset at byte 22 with a held record, then a clean frame
        send_frame(22, 16'h88B5, 64'hDEAD, 64'hBEEF, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0; tvalid = 1'b1; tready = 1'b1; tdata = fbyte(22, 16'h88B5, 64'hDEAD);
        @(negedge clk);
        tdata = fbyte(23, 16'h88B5, 64'hDEAD);
        @(negedge clk);
        rst_n = 1'b1; tvalid = 1'b0; tready = 1'b0;
        chk("t8_valid", 64'(res_valid), 64'd0);
        chk("t8_frames", 64'(cnt_frames), 64'd0);
        chk("t8_crit", 64'(cnt_critical), 64'd0);
        chk("t8_runt", 64'(cnt_runt), 64'd0);
        chk("t8_ovf", 64'(cnt_overflow), 64'd0);
        send_frame(64, 16'h88B5, 64'h1234, 64'h2234, 1'b0, 1'b0, 1'b0);
        chk("t8b_valid", 64'(res_valid), 64'd1);
        chk("t8b_tx", res_tx_ts, 64'h1234);
        chk("t8b_lat", res_latency, 64'h1000);
        chk("t8b_frames", 64'(cnt_frames), 64'd1);
        chk("t8b_crit", 64'(cnt_critical), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
